vga_rx_decoder: RTL and testbench
=================================

Name: vga_rx_decoder

Overview:
- Receive-side counterpart of the VGA timing generator and pixel mux: samples hsync/vsync/RGB at the pixel rate, recovers pixel coordinates and data-enable, and checks 640x480@60 timing.
- Produces a per-frame pixel checksum and error counters.
- Used as an on-chip loopback monitor and as the bench checker for the game's video output.

Parameters:
H_TOTAL, 800, pixels per line
H_SYNC, 96, hsync width in pixels
H_BP, 48, pixels from hsync leading edge end-of-pulse to first active pixel
H_ACTIVE, 640, active pixels per line
V_TOTAL, 525, lines per frame
V_SYNC, 2, vsync width in lines
V_BP, 33, lines after vsync pulse before first active line
V_ACTIVE, 480, active lines per frame
SYNC_ACT_LOW, 1, 1 = syncs active-low

Ports:
clk  in  1  system clock, 100 MHz
rst  in  1  reset; asynchronous, active-high
pixpulse  in  1  one-clk sample strobe, every 4 clocks
hsync_in  in  1  received hsync
vsync_in  in  1  received vsync
rgb_in  in  12  received pixel {R,G,B} 4:4:4
locked  out  1  timing locked
rx_valid  out  1  one-clk pulse per active pixel sample
rx_x  out  10  active pixel column 0..639
rx_y  out  10  active line 0..479
rx_pixel  out  12  pixel sampled with rx_x/rx_y
frame_done  out  1  one-clk pulse; frame_sum valid
frame_sum  out  16  checksum of last good frame
sync_err  out  1  one-clk pulse on any timing violation
err_count  out  8  violations since reset, saturates at 255

Behaviour:
- All inputs are sampled only on pixpulse. Outputs are registered and update in the clk cycle after the sampling pixpulse (latency 1 clk). Pulse outputs are high for exactly one clk.
- Reset values: all outputs 0, state SEARCH, all counters 0.
- Sync normalisation: hs = hsync_in XOR SYNC_ACT_LOW; vs likewise. 1 = asserted.
- Line edge (LE): a sample where hs=1 and the previous sample had hs=0.
- h_cnt: 0 on an LE sample, else +1, saturating at 1023.
- hs_w counts asserted samples. At the hs 1->0 sample, hs_w != H_SYNC is a violation.
- Vsync is sampled only at LE. Frame start (FS) is an LE where vs=1 and vs was 0 at the previous LE.
- v_cnt: 0 at FS, +1 at every other LE, saturating at 1023.
- Active region (DE): H_SYNC+H_BP <= h_cnt < H_SYNC+H_BP+H_ACTIVE, and V_SYNC+V_BP <= v_cnt < V_SYNC+V_BP+V_ACTIVE.
  - rx_x = h_cnt-(H_SYNC+H_BP).
  - rx_y = v_cnt-(V_SYNC+V_BP).
- State machine:
  - SEARCH: locked=0, counts run, no error checks. On FS -> ALIGN.
  - ALIGN: locked=0. Track whether every LE had h_cnt==H_TOTAL-1 on the preceding sample (line length H_TOTAL) and hsync width was correct.
    - On next FS with all lines good and v_cnt==V_TOTAL-1 -> LOCKED.
    - Otherwise stay in ALIGN and restart tracking from this FS. No sync_err raised.
  - LOCKED: locked=1. Violations:
    - LE with line length != H_TOTAL
    - h_cnt reaching H_TOTAL with no LE
    - hsync width mismatch
    - FS with v_cnt != V_TOTAL-1
    - vs asserted at an LE with v_cnt >= V_SYNC (vsync too long)
  - On any violation: sync_err pulse, err_count+1 (saturating), -> SEARCH, locked=0 on the same update.
- rx_valid pulses only in LOCKED and DE. rx_pixel = rgb_in from that sample.
- Checksum: acc += zero-extended rgb_in on each rx_valid sample, mod 2^16. acc clears at every FS.
- frame_done: at an FS in LOCKED that raises no violation, provided the previous FS was also seen in LOCKED (full frame accumulated).
  - frame_sum <= acc before the clear.
  - frame_done pulses.
  - frame_sum holds until the next frame_done.
- Simultaneous events: violation and FS on the same sample → violation wins; no frame_done, frame_sum unchanged.
- rst mid-frame returns to SEARCH immediately and clears err_count.
- pixpulse gaps do not advance any counter.

Test Plan:
- Nominal lock:
  - Stimulus: drive from vga_timing with a constant 12'h000 picture.
  - Required: locked rises at the second FS after reset release. First frame_done at the third FS with frame_sum=16'h0000. sync_err never asserts.
- All-white frame:
  - Stimulus: rgb_in=12'hFFF everywhere, once locked.
  - Required: exactly 307200 rx_valid pulses per frame, frame_sum=16'h5000.
- Coordinate check:
  - Stimulus: a single pixel 12'h0F0 at (639,479), black elsewhere.
  - Required: rx_valid with rx_x=639, rx_y=479, rx_pixel=12'h0F0. frame_sum=16'h00F0.
- Short line:
  - Stimulus: while locked, one line of 799 samples.
  - Required: sync_err pulse, err_count=1, locked=0. Relock after two further good FS.
- Bad hsync width:
  - Stimulus: while locked, hsync pulse of 95 samples.
  - Required: sync_err, err_count increments, no frame_done at the next FS.
- Mid-frame reset:
  - Stimulus: rst asserted mid-frame with err_count=3.
  - Required: all outputs 0 asynchronously, err_count=0. Normal relock afterwards.

Source files
------------

// File: rtl/vga_rx_decoder.sv
// vga_rx_decoder: recovers VGA timing, pixel coordinates, per-frame checksum and sync error counts
module vga_rx_decoder #(
    parameter logic [9:0] H_TOTAL      = 10'd800,
    parameter logic [9:0] H_SYNC       = 10'd96,
    parameter logic [9:0] H_BP         = 10'd48,
    parameter logic [9:0] H_ACTIVE     = 10'd640,
    parameter logic [9:0] V_TOTAL      = 10'd525,
    parameter logic [9:0] V_SYNC       = 10'd2,
    parameter logic [9:0] V_BP         = 10'd33,
    parameter logic [9:0] V_ACTIVE     = 10'd480,
    parameter logic       SYNC_ACT_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pixpulse,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic [11:0] rgb_in,
    output logic        locked,
    output logic        rx_valid,
    output logic [9:0]  rx_x,
    output logic [9:0]  rx_y,
    output logic [11:0] rx_pixel,
    output logic        frame_done,
    output logic [15:0] frame_sum,
    output logic        sync_err,
    output logic [7:0]  err_count
);
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;
    localparam logic [9:0] H_LAST = H_TOTAL - 10'd1;
    localparam logic [9:0] V_LAST = V_TOTAL - 10'd1;
    localparam logic [9:0] H_DE0  = H_SYNC + H_BP;
    localparam logic [9:0] H_DE1  = H_DE0 + H_ACTIVE;
    localparam logic [9:0] V_DE0  = V_SYNC + V_BP;
    localparam logic [9:0] V_DE1  = V_DE0 + V_ACTIVE;
    localparam logic [9:0] SAT    = 10'h3FF;

    logic [1:0]  state, state_nxt;
    logic        prev_hs, prev_vs, good, good_nxt, armed;
    logic [9:0]  h_cnt, v_cnt, hs_w, h_nxt, v_nxt, hs_w_nxt;
    logic [15:0] acc;
    logic        hs, vs, le, fall, fs, h_ok, w_bad, viol, de, valid_nxt;

    assign locked = state == LOCKED;

    always_comb begin
        hs        = hsync_in ^ SYNC_ACT_LOW;
        vs        = vsync_in ^ SYNC_ACT_LOW;
        le        = hs && !prev_hs;
        fall      = !hs && prev_hs;
        fs        = le && vs && !prev_vs;
        h_ok      = h_cnt == H_LAST;
        w_bad     = fall && (hs_w != H_SYNC);
        h_nxt     = le ? 10'd0 : h_cnt + {9'd0, h_cnt != SAT};
        v_nxt     = fs ? 10'd0 : le ? v_cnt + {9'd0, v_cnt != SAT} : v_cnt;
        hs_w_nxt  = le ? 10'd1 : hs ? hs_w + {9'd0, hs_w != SAT} : hs_w;
        // a line running past H_TOTAL without an edge is caught on the sample that would reach H_TOTAL
        viol      = (state == LOCKED) && ((le && !h_ok) || (!le && h_ok) || w_bad ||
                    (fs && v_cnt != V_LAST) || (le && vs && !fs && v_nxt >= V_SYNC));
        state_nxt = viol ? SEARCH :
                    (state == SEARCH && fs) ? ALIGN :
                    (state == ALIGN && fs && good && h_ok && v_cnt == V_LAST) ? LOCKED : state;
        good_nxt  = fs ? 1'b1 : ((le && !h_ok) || w_bad) ? 1'b0 : good;
        de        = (h_nxt >= H_DE0) && (h_nxt < H_DE1) && (v_nxt >= V_DE0) && (v_nxt < V_DE1);
        valid_nxt = (state_nxt == LOCKED) && de;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= SEARCH;
            prev_hs    <= 1'b0;
            prev_vs    <= 1'b0;
            good       <= 1'b0;
            armed      <= 1'b0;
            h_cnt      <= 10'd0;
            v_cnt      <= 10'd0;
            hs_w       <= 10'd0;
            acc        <= 16'd0;
            rx_valid   <= 1'b0;
            rx_x       <= 10'd0;
            rx_y       <= 10'd0;
            rx_pixel   <= 12'd0;
            frame_done <= 1'b0;
            frame_sum  <= 16'd0;
            sync_err   <= 1'b0;
            err_count  <= 8'd0;
        end else begin
            rx_valid   <= 1'b0;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
            if (pixpulse) begin
                state    <= state_nxt;
                prev_hs  <= hs;
                h_cnt    <= h_nxt;
                v_cnt    <= v_nxt;
                hs_w     <= hs_w_nxt;
                good     <= good_nxt;
                rx_valid <= valid_nxt;
                acc      <= fs ? 16'd0 : valid_nxt ? acc + {4'd0, rgb_in} : acc;
                if (le) prev_vs <= vs;
                if (fs) armed <= state_nxt == LOCKED;
                if (valid_nxt) begin
                    rx_x     <= h_nxt - H_DE0;
                    rx_y     <= v_nxt - V_DE0;
                    rx_pixel <= rgb_in;
                end
                if (fs && state == LOCKED && !viol && armed) begin
                    frame_done <= 1'b1;
                    frame_sum  <= acc;
                end
                if (viol) begin
                    sync_err  <= 1'b1;
                    err_count <= err_count + {7'd0, err_count != 8'hFF};
                end
            end
        end
    end
endmodule

// File: tb/tb_vga_rx_decoder.sv
// tb_vga_rx_decoder: directed checks of lock, checksum, coordinates and sync errors on a reduced raster
module tb_vga_rx_decoder;
    localparam int HT = 24, HS = 4, HB = 3, HA = 16;
    localparam int VT = 12, VS = 2, VB = 2, VA = 6;

    logic        clk = 0, rst = 0, pixpulse = 0, hsync_in = 1, vsync_in = 1;
    logic [11:0] rgb_in = 0;
    logic        locked, rx_valid, frame_done, sync_err;
    logic [9:0]  rx_x, rx_y;
    logic [11:0] rx_pixel;
    logic [15:0] frame_sum;
    logic [7:0]  err_count;

    int n_checks = 0, n_errors = 0, frame_no = 0;
    int n_valid = 0, n_done = 0, n_err = 0, n_hit = 0;
    int lock_frame = 0, done_frame = 0, hit_x = 0, hit_y = 0, hit_pix = 0, last_sum = -1;
    int snap;
    logic locked_q = 0;

    vga_rx_decoder #(
        .H_TOTAL(10'(HT)), .H_SYNC(10'(HS)), .H_BP(10'(HB)), .H_ACTIVE(10'(HA)),
        .V_TOTAL(10'(VT)), .V_SYNC(10'(VS)), .V_BP(10'(VB)), .V_ACTIVE(10'(VA)),
        .SYNC_ACT_LOW(1'b1)
    ) dut (
        .clk(clk), .rst(rst), .pixpulse(pixpulse), .hsync_in(hsync_in), .vsync_in(vsync_in),
        .rgb_in(rgb_in), .locked(locked), .rx_valid(rx_valid), .rx_x(rx_x), .rx_y(rx_y),
        .rx_pixel(rx_pixel), .frame_done(frame_done), .frame_sum(frame_sum),
        .sync_err(sync_err), .err_count(err_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (rx_valid && rx_pixel != 12'd0) begin
            n_hit++;
            hit_x = int'(rx_x);
            hit_y = int'(rx_y);
            hit_pix = int'(rx_pixel);
        end
        if (frame_done) begin
            n_done++;
            done_frame = frame_no;
            last_sum = int'(frame_sum);
        end
        if (sync_err) n_err++;
        if (locked && !locked_q) lock_frame = frame_no;
        locked_q = locked;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // mode 0 black, 1 white, 2 single 0F0 pixel at active (15,5)
    task automatic send_frame(input int mode, input int lines, input int short_ln, input int bad_ln, input int vsl);
        frame_no++;
        for (int v = 0; v < lines; v++)
            for (int h = 0; h < (v == short_ln ? HT - 1 : HT); h++) begin
                @(negedge clk);
                hsync_in = !(h < (v == bad_ln ? HS - 1 : HS));
                vsync_in = !(v < vsl);
                rgb_in   = mode == 1 ? 12'hFFF : (mode == 2 && h == HS + HB + 15 && v == VS + VB + 5) ? 12'h0F0 : 12'h000;
                pixpulse = 1;
                @(negedge clk);
                pixpulse = 0;
                repeat (2) @(negedge clk);
            end
    endtask

    initial begin
        #2 rst = 1;
        repeat (3) @(negedge clk);
        chk("rst_locked", 32'(locked), 0);
        chk("rst_valid", 32'(rx_valid), 0);
        chk("rst_sync_err", 32'(sync_err), 0);
        chk("rst_err_count", 32'(err_count), 0);
        chk("rst_frame_sum", 32'(frame_sum), 0);
        chk("rst_rx_x", 32'(rx_x), 0);
        rst = 0;

        repeat (3) send_frame(0, VT, -1, -1, VS);
        chk("lock_at_fs2", 32'(lock_frame), 2);
        chk("first_done_fs3", 32'(done_frame), 3);
        chk("first_done_count", 32'(n_done), 1);
        chk("black_sum", 32'(last_sum), 32'h0000);
        chk("nominal_no_err", 32'(n_err), 0);
        chk("nominal_locked", 32'(locked), 1);

        snap = n_valid;
        send_frame(1, VT, -1, -1, VS);
        chk("white_valid_count", 32'(n_valid - snap), 96);
        send_frame(0, VT, -1, -1, VS);
        chk("white_sum", 32'(last_sum), 32'hFFA0);

        snap = n_hit;
        send_frame(2, VT, -1, -1, VS);
        chk("coord_hits", 32'(n_hit - snap), 1);
        chk("coord_x", 32'(hit_x), 15);
        chk("coord_y", 32'(hit_y), 5);
        chk("coord_pix", 32'(hit_pix), 32'h0F0);
        chk("last_rx_x", 32'(rx_x), 15);
        chk("last_rx_y", 32'(rx_y), 5);
        send_frame(0, VT, -1, -1, VS);
        chk("coord_sum", 32'(last_sum), 32'h00F0);
        chk("pre_fault_no_err", 32'(n_err), 0);

        send_frame(0, VT, 5, -1, VS);
        chk("short_sync_err", 32'(n_err), 1);
        chk("short_err_count", 32'(err_count), 1);
        chk("short_unlocked", 32'(locked), 0);
        send_frame(0, VT, -1, -1, VS);
        chk("short_still_unlocked", 32'(locked), 0);
        send_frame(0, VT, -1, -1, VS);
        chk("short_relock_frame", 32'(lock_frame), 10);
        chk("short_relocked", 32'(locked), 1);

        send_frame(0, VT, -1, 3, VS);
        chk("hsw_sync_err", 32'(n_err), 2);
        chk("hsw_err_count", 32'(err_count), 2);
        snap = n_done;
        send_frame(0, VT, -1, -1, VS);
        chk("hsw_no_done", 32'(n_done), 32'(snap));
        send_frame(0, VT, -1, -1, VS);
        chk("hsw_relocked", 32'(locked), 1);

        send_frame(0, VT, -1, -1, VS + 1);
        chk("vlong_err_count", 32'(err_count), 3);
        chk("vlong_unlocked", 32'(locked), 0);
        send_frame(0, VT, -1, -1, VS);
        send_frame(1, VT, -1, -1, VS);
        chk("pre_rst_lock_frame", 32'(lock_frame), 16);
        send_frame(0, 5, -1, -1, VS);
        chk("pre_rst_sum", 32'(last_sum), 32'hFFA0);
        chk("pre_rst_locked", 32'(locked), 1);

        #3 rst = 1;
        #1;
        chk("async_rst_locked", 32'(locked), 0);
        chk("async_rst_err_count", 32'(err_count), 0);
        chk("async_rst_frame_sum", 32'(frame_sum), 0);
        chk("async_rst_rx_x", 32'(rx_x), 0);
        chk("async_rst_rx_y", 32'(rx_y), 0);
        repeat (2) @(negedge clk);
        rst = 0;
        snap = n_err;
        repeat (3) send_frame(0, VT, -1, -1, VS);
        chk("post_rst_lock_frame", 32'(lock_frame), 19);
        chk("post_rst_done_frame", 32'(done_frame), 20);
        chk("post_rst_sum", 32'(last_sum), 32'h0000);
        chk("post_rst_no_err", 32'(n_err - snap), 0);
        chk("post_rst_err_count", 32'(err_count), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
